// File: rtl/inst_sram_responder_pkg.sv
// rtl/inst_sram_responder_pkg.sv - shared types and constants for the instruction SRAM responder
package inst_sram_responder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } resp_state_e;

   localparam logic [15:0] LFSR_SEED          = 16'hACE1;
   localparam int          DEFAULT_DATA_DELAY = 0;

   // Fibonacci LFSR, taps x^16 + x^14 + x^13 + x^11 + 1
   function automatic logic [15:0] lfsr_next(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/inst_sram_responder_resp_addr_fifo.sv
// rtl/inst_sram_responder_resp_addr_fifo.sv - synchronous FIFO holding queued word addresses
module resp_addr_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem_q[rd_q];

   // next pointers and occupancy; simultaneous push and pop leaves the count unchanged
   always_comb begin
      wr_d  = do_push ? ptr_inc(wr_q) : wr_q;
      rd_d  = do_pop  ? ptr_inc(rd_q) : rd_q;
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // storage write; contents need no reset since occupancy gates reads
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din;
   end

endmodule

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - in-order instruction SRAM responder; INST_SRAM_RESP_RAND_DELAY_EN adds LFSR delay and back-pressure
module inst_sram_responder
   import inst_sram_responder_pkg::*;
#(
   parameter int OUTSTANDING = 2,
   parameter int DATA_DELAY  = DEFAULT_DATA_DELAY,
   parameter int RAM_AW      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_sram_req,
   input  logic [31:0]       inst_sram_addr,
   output logic              inst_sram_addr_ok,
   output logic              inst_sram_data_ok,
   output logic [31:0]       inst_sram_rdata,
   output logic              ram_en,
   output logic [RAM_AW-1:0] ram_addr,
   input  logic [31:0]       ram_rdata
);

   resp_state_e       state_q, state_d;
   logic [4:0]        cnt_q, cnt_d;
   logic [4:0]        dly_load;
   logic [31:0]       rdata_q, rdata_d;
   logic              fire;
   logic              fifo_full, fifo_empty;
   logic              bp_mask;
   logic [RAM_AW-1:0] head_addr;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{inst_sram_addr[31:RAM_AW+2], inst_sram_addr[1:0]};

`ifdef INST_SRAM_RESP_RAND_DELAY_EN
   logic [15:0] lfsr_q, lfsr_d;

   assign lfsr_d   = lfsr_next(lfsr_q);
   assign dly_load = 5'(DATA_DELAY) + {3'b000, lfsr_q[1:0]};
   assign bp_mask  = lfsr_q[15];

   // free-running LFSR providing jitter and back-pressure
   always_ff @(posedge clk) begin
      if (reset) lfsr_q <= LFSR_SEED;
      else       lfsr_q <= lfsr_d;
   end
`else
   assign dly_load = 5'(DATA_DELAY);
   assign bp_mask  = 1'b0;
`endif

   // full comes from registered occupancy only, so no pop-to-addr_ok path
   assign inst_sram_addr_ok = inst_sram_req && !fifo_full && !reset && !bp_mask;

   resp_addr_fifo #(
      .DEPTH (OUTSTANDING),
      .WIDTH (RAM_AW)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (inst_sram_addr_ok),
      .pop   (fire),
      .din   (inst_sram_addr[RAM_AW+1:2]),
      .dout  (head_addr),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign ram_en            = fire && !reset;
   assign ram_addr          = head_addr;
   assign inst_sram_data_ok = (state_q == ST_RESP) && !reset;
   assign inst_sram_rdata   = (state_q == ST_RESP) ? ram_rdata : rdata_q;
   assign rdata_d           = (state_q == ST_RESP) ? ram_rdata : rdata_q;

   // service FSM: IDLE behaves as a WAIT entry so a zero delay reads the head immediately
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      fire    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               if (dly_load == 5'd0) begin
                  fire    = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = dly_load - 5'd1;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 5'd0) begin
               fire    = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         ST_RESP: begin
            if (!fifo_empty) begin
               cnt_d   = dly_load;
               state_d = ST_WAIT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state, delay counter and held response word
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

endmodule

// File: tb/tb_inst_sram_responder.sv
// tb/tb_inst_sram_responder.sv - randomized scoreboard bench for inst_sram_responder
module tb_inst_sram_responder;

   localparam int NI = 2;
   localparam int AW = 4;
   localparam int MAXT = 2048;

   int dly  [NI] = '{0, 3};
   int outs [NI] = '{2, 4};

   logic          clk = 1'b0;
   logic          reset;
   logic          req       [NI];
   logic [31:0]   addr      [NI];
   logic          addr_ok   [NI];
   logic          data_ok   [NI];
   logic [31:0]   rdata     [NI];
   logic          ram_en    [NI];
   logic [AW-1:0] ram_addr  [NI];
   logic [31:0]   ram_rdata [NI];
   logic [31:0]   mem [2**AW];

   always #5 clk = ~clk;

   inst_sram_responder #(.OUTSTANDING(2), .DATA_DELAY(0), .RAM_AW(AW)) u_dut0 (
      .clk(clk), .reset(reset), .inst_sram_req(req[0]), .inst_sram_addr(addr[0]),
      .inst_sram_addr_ok(addr_ok[0]), .inst_sram_data_ok(data_ok[0]), .inst_sram_rdata(rdata[0]),
      .ram_en(ram_en[0]), .ram_addr(ram_addr[0]), .ram_rdata(ram_rdata[0]));

   inst_sram_responder #(.OUTSTANDING(4), .DATA_DELAY(3), .RAM_AW(AW)) u_dut3 (
      .clk(clk), .reset(reset), .inst_sram_req(req[1]), .inst_sram_addr(addr[1]),
      .inst_sram_addr_ok(addr_ok[1]), .inst_sram_data_ok(data_ok[1]), .inst_sram_rdata(rdata[1]),
      .ram_en(ram_en[1]), .ram_addr(ram_addr[1]), .ram_rdata(ram_rdata[1]));

   // behavioural 1-cycle-latency block RAM per instance
   always @(posedge clk) begin
      for (int i = 0; i < NI; i++)
         if (ram_en[i]) ram_rdata[i] <= mem[ram_addr[i]];
   end

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   // transaction-level model: accepted word address and the cycle its RAM read must happen
   int acc_wa  [NI][MAXT];
   int fire_t  [NI][MAXT];
   int n_acc   [NI];
   int n_fired [NI];
   int n_resp  [NI];
   logic acc_last [NI];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // one clock cycle: inputs already set by caller, check at negedge, advance model
   task automatic step(input logic rst);
      int occ, f, prev;
      logic exp_ok, exp_en, exp_dok;
      reset = rst;
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
         acc_last[i] = 1'b0;
         if (rst) begin
            check($sformatf("u%0d.rst_addr_ok@%0d", i, cyc), 32'(addr_ok[i]), 32'd0);
            check($sformatf("u%0d.rst_data_ok@%0d", i, cyc), 32'(data_ok[i]), 32'd0);
            check($sformatf("u%0d.rst_ram_en@%0d", i, cyc), 32'(ram_en[i]), 32'd0);
            n_acc[i] = 0; n_fired[i] = 0; n_resp[i] = 0;
         end else begin
            while (n_fired[i] < n_acc[i] && fire_t[i][n_fired[i]] < cyc) n_fired[i]++;
            occ    = n_acc[i] - n_fired[i];
            exp_ok = req[i] && (occ < outs[i]);
            check($sformatf("u%0d.addr_ok@%0d", i, cyc), 32'(addr_ok[i]), 32'(exp_ok));
            exp_en = (n_fired[i] < n_acc[i]) && (fire_t[i][n_fired[i]] == cyc);
            check($sformatf("u%0d.ram_en@%0d", i, cyc), 32'(ram_en[i]), 32'(exp_en));
            if (exp_en)
               check($sformatf("u%0d.ram_addr@%0d", i, cyc), 32'(ram_addr[i]), 32'(acc_wa[i][n_fired[i]]));
            exp_dok = (n_resp[i] < n_acc[i]) && (fire_t[i][n_resp[i]] + 1 == cyc);
            check($sformatf("u%0d.data_ok@%0d", i, cyc), 32'(data_ok[i]), 32'(exp_dok));
            if (exp_dok) begin
               check($sformatf("u%0d.rdata@%0d", i, cyc), rdata[i], mem[acc_wa[i][n_resp[i]]]);
               n_resp[i]++;
            end
            if (exp_ok && n_acc[i] < MAXT) begin
               // service starts one cycle after accept or after the previous response, plus delay
               prev = (n_acc[i] > 0) ? fire_t[i][n_acc[i]-1] + 2 : 0;
               f    = ((cyc + 1) > prev ? (cyc + 1) : prev) + dly[i];
               acc_wa[i][n_acc[i]] = int'(addr[i][AW+1:2]);
               fire_t[i][n_acc[i]] = f;
               n_acc[i]++;
               acc_last[i] = 1'b1;
            end
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         for (int i = 0; i < NI; i++) req[i] = 1'b0;
         step(1'b0);
      end
   endtask

   initial begin
      int k [NI];
      int accs;
      for (int j = 0; j < 2**AW; j++) mem[j] = $urandom;
      mem[0] = 32'h2402_0001;
      for (int i = 0; i < NI; i++) begin
         req[i] = 1'b1; addr[i] = 32'hBFC0_0040; n_acc[i] = 0; n_fired[i] = 0; n_resp[i] = 0;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;

      // reset with req asserted: nothing accepted, outputs quiet
      step(1'b1);
      step(1'b1);
      for (int i = 0; i < NI; i++) begin
         check($sformatf("u%0d.rst_rdata", i), rdata[i], 32'd0);
         check($sformatf("u%0d.rst_data_ok", i), 32'(data_ok[i]), 32'd0);
      end
      idle(2);

      // single read at an address whose word index wraps to 0
      for (int i = 0; i < NI; i++) begin req[i] = 1'b1; addr[i] = 32'hBFC0_0040; end
      step(1'b0);
      idle(8);

      // queue full: req held four cycles regardless of accepts
      for (int c = 0; c < 4; c++) begin
         for (int i = 0; i < NI; i++) begin req[i] = 1'b1; addr[i] = 32'(c * 4); end
         step(1'b0);
      end
      idle(20);

      // back-to-back stream of 8 sequential words, address held until accepted
      for (int i = 0; i < NI; i++) k[i] = 0;
      for (int c = 0; c < 100 && (k[0] < 8 || k[1] < 8); c++) begin
         for (int i = 0; i < NI; i++) begin
            req[i]  = (k[i] < 8);
            addr[i] = 32'h0000_0100 + 32'(k[i] * 4);
         end
         step(1'b0);
         for (int i = 0; i < NI; i++) if (acc_last[i]) k[i]++;
      end
      for (int i = 0; i < NI; i++) check($sformatf("u%0d.b2b_accepts", i), 32'(k[i]), 32'd8);
      idle(50);
      for (int i = 0; i < NI; i++) check($sformatf("u%0d.b2b_drain", i), 32'(n_resp[i]), 32'(n_acc[i]));

      // reset one cycle after two accepts: pending work dropped, fresh request nominal
      accs = 0;
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < NI; i++) begin req[i] = 1'b1; addr[i] = 32'(c * 4 + 8); end
         step(1'b0);
         accs += int'(acc_last[0]) + int'(acc_last[1]);
      end
      check("midrst_accepts", 32'(accs), 32'd4);
      for (int i = 0; i < NI; i++) req[i] = 1'b0;
      step(1'b1);
      idle(10);
      for (int i = 0; i < NI; i++) begin req[i] = 1'b1; addr[i] = 32'h0000_0014; end
      step(1'b0);
      idle(8);
      for (int i = 0; i < NI; i++) check($sformatf("u%0d.midrst_done", i), 32'(n_resp[i]), 32'd1);

      // randomized traffic against the scoreboard
      for (int c = 0; c < 800; c++) begin
         for (int i = 0; i < NI; i++) begin
            req[i]  = ($urandom_range(0, 3) != 0);
            addr[i] = $urandom;
         end
         step(1'b0);
      end
      idle(40);
      for (int i = 0; i < NI; i++) check($sformatf("u%0d.rand_drain", i), 32'(n_resp[i]), 32'(n_acc[i]));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
